// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, receiver state encoding and
// the 3-sample majority helper used by the oversampling front end.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    RX_IDLE     = 3'd0,
    RX_START    = 3'd1,
    RX_DATA     = 3'd2,
    RX_PARITY   = 3'd3,
    RX_STOP     = 3'd4,
    RX_BRK_WAIT = 3'd5
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampling front end: synchronises the serial line, counts sample ticks
// within a bit period and votes the bit value from three mid-bit samples.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  input  logic sample_tick,
  input  logic restart,
  output logic rx_s,
  output logic rx_fall,
  output logic bit_strobe,
  output logic bit_val,
  output logic bit_end
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] SAMP_A = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] SAMP_B = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] SAMP_C = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] LAST   = CW'(OVERSAMPLE - 1);

  logic          rx_meta;
  logic          rx_prev;
  logic [CW-1:0] tick_cnt;
  logic          samp_a;
  logic          samp_b;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign rx_fall = rx_prev & ~rx_s;

  // Position within the current bit period; restart realigns it to a new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (restart) begin
      tick_cnt <= '0;
    end else if (sample_tick) begin
      tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + CW'(1);
    end
  end

  // Capture the first two mid-bit samples; the third is taken live at the vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (sample_tick) begin
      if (tick_cnt == SAMP_A) samp_a <= rx_s;
      if (tick_cnt == SAMP_B) samp_b <= rx_s;
    end
  end

  assign bit_strobe = sample_tick && (tick_cnt == SAMP_C);
  assign bit_val    = majority3(samp_a, samp_b, rx_s);
  assign bit_end    = sample_tick && (tick_cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: frame FSM with parity, framing and break
// checks feeding a one-entry valid/ready holding register.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  sample_tick,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  break_det,
  output logic                  busy
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  rx_state_t             state;
  rx_state_t             state_nxt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bad;
  logic                  frame_bad;
  logic                  all_zero;
  logic                  stop_idx;
  logic                  rx_s;
  logic                  rx_fall;
  logic                  bit_strobe;
  logic                  bit_val;
  logic                  bit_end;
  logic                  restart;
  logic                  last_stop;
  logic                  stop_done;
  logic                  brk_hit;
  logic                  commit;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .sample_tick(sample_tick),
    .restart    (restart),
    .rx_s       (rx_s),
    .rx_fall    (rx_fall),
    .bit_strobe (bit_strobe),
    .bit_val    (bit_val),
    .bit_end    (bit_end)
  );

  assign last_stop = (STOP_BITS == 1) || stop_idx;
  assign stop_done = (state == RX_STOP) && bit_strobe && last_stop;
  assign brk_hit   = stop_done && all_zero && !bit_val;
  assign commit    = stop_done && !brk_hit;
  assign restart   = (state_nxt != state);
  assign busy      = (state != RX_IDLE);

  // Frame sequencing; the final stop bit exits at its vote so the next start edge is caught early.
  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:     if (rx_fall) state_nxt = RX_START;
      RX_START: begin
        if (bit_strobe && bit_val) state_nxt = RX_IDLE;
        else if (bit_end)          state_nxt = RX_DATA;
      end
      RX_DATA: begin
        if (bit_end && (bit_cnt == BW'(DATA_WIDTH)))
          state_nxt = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
      end
      RX_PARITY:   if (bit_end) state_nxt = RX_STOP;
      RX_STOP:     if (stop_done) state_nxt = brk_hit ? RX_BRK_WAIT : RX_IDLE;
      RX_BRK_WAIT: if (rx_s) state_nxt = RX_IDLE;
      default:     state_nxt = RX_IDLE;
    endcase
  end

  // Per-frame datapath: shift data, evaluate parity, collect stop errors and track an all-zero frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RX_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bad   <= 1'b0;
      frame_bad <= 1'b0;
      all_zero  <= 1'b1;
      stop_idx  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        RX_IDLE: begin
          bit_cnt   <= '0;
          par_bad   <= 1'b0;
          frame_bad <= 1'b0;
          all_zero  <= 1'b1;
          stop_idx  <= 1'b0;
        end
        RX_DATA: begin
          if (bit_strobe) begin
            shreg   <= {bit_val, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_val) all_zero <= 1'b0;
          end
          if (state_nxt != RX_DATA) bit_cnt <= '0;
        end
        RX_PARITY: begin
          if (bit_strobe) begin
            par_bad <= (PARITY == PAR_ODD) ? ~(^shreg ^ bit_val) : (^shreg ^ bit_val);
            if (bit_val) all_zero <= 1'b0;
          end
        end
        RX_STOP: begin
          if (bit_strobe && !bit_val) frame_bad <= 1'b1;
          if (bit_strobe && bit_val)  all_zero  <= 1'b0;
          if (bit_end)                stop_idx  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Holding register: a commit lands if the slot is free or being drained this cycle, otherwise it is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      break_det   <= brk_hit;
      if (commit && (!data_valid || data_ready)) begin
        data_out   <= shreg;
        parity_err <= par_bad;
        frame_err  <= frame_bad | ~bit_val;
        data_valid <= 1'b1;
      end else begin
        if (commit) overrun_err <= 1'b1;
        if (data_valid && data_ready) data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: four instances cover 8N1, 8E1, 8O1 and 8N2.
// Stimulus pushes expected words; a negedge monitor pops on every transfer.
module tb_uart_rx_os;

  localparam int BIT_CLKS = 64;

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       sample_tick;
  logic       rxl  [4];
  logic       rdy  [4];
  logic [7:0] dout [4];
  logic       dval [4];
  logic       perr [4];
  logic       ferr [4];
  logic       ovr  [4];
  logic       brk  [4];
  logic       bsy  [4];

  exp_t sb[$];
  int   n_cmp;
  int   n_fail;
  int   ovr_cnt [4];
  int   brk_cnt [4];

  uart_rx_os #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_n1 (
    .clk(clk), .rst(rst), .rx_in(rxl[0]), .sample_tick(sample_tick),
    .data_out(dout[0]), .data_valid(dval[0]), .data_ready(rdy[0]),
    .parity_err(perr[0]), .frame_err(ferr[0]), .overrun_err(ovr[0]),
    .break_det(brk[0]), .busy(bsy[0]));

  uart_rx_os #(.DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16)) u_e1 (
    .clk(clk), .rst(rst), .rx_in(rxl[1]), .sample_tick(sample_tick),
    .data_out(dout[1]), .data_valid(dval[1]), .data_ready(rdy[1]),
    .parity_err(perr[1]), .frame_err(ferr[1]), .overrun_err(ovr[1]),
    .break_det(brk[1]), .busy(bsy[1]));

  uart_rx_os #(.DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) u_o1 (
    .clk(clk), .rst(rst), .rx_in(rxl[2]), .sample_tick(sample_tick),
    .data_out(dout[2]), .data_valid(dval[2]), .data_ready(rdy[2]),
    .parity_err(perr[2]), .frame_err(ferr[2]), .overrun_err(ovr[2]),
    .break_det(brk[2]), .busy(bsy[2]));

  uart_rx_os #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16)) u_n2 (
    .clk(clk), .rst(rst), .rx_in(rxl[3]), .sample_tick(sample_tick),
    .data_out(dout[3]), .data_valid(dval[3]), .data_ready(rdy[3]),
    .parity_err(perr[3]), .frame_err(ferr[3]), .overrun_err(ovr[3]),
    .break_det(brk[3]), .busy(bsy[3]));

  // 100 MHz system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One sample_tick every 4 clocks gives a 64-clock bit period at 16x oversampling
  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 sample_tick = 1'b1;
      @(posedge clk);
      #1 sample_tick = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectWord(input int d, input logic [7:0] data, input logic pe, input logic fe);
    exp_t e;
    e.dut  = d;
    e.data = data;
    e.perr = pe;
    e.ferr = fe;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] mkFrame(input logic [7:0] data, input bit has_par, input logic par,
                                          input logic s1, input logic s2);
    logic [15:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = data;
    if (has_par) begin
      f[9]  = par;
      f[10] = s1;
      f[11] = s2;
    end else begin
      f[9]  = s1;
      f[10] = s2;
    end
    return f;
  endfunction

  // Drive one frame (LSB first, start bit at index 0) aligned to a tick, then one idle bit.
  // noise_at inverts the line for one tick period; ready_at raises data_ready at that clock offset.
  task automatic applyStimulus(input int d, input logic [15:0] frame, input int nbits,
                               input int noise_at, input int ready_at);
    logic v;
    int   b;
    @(posedge clk iff sample_tick);
    #1;
    for (int c = 0; c < (nbits + 1) * BIT_CLKS; c++) begin
      b = c / BIT_CLKS;
      v = (b < nbits) ? frame[b] : 1'b1;
      if (noise_at >= 0 && c >= noise_at && c < noise_at + 4) v = ~v;
      rxl[d] = v;
      if (c == ready_at) rdy[d] = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: count error pulses and check every accepted word against the scoreboard
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (ovr[d]) ovr_cnt[d]++;
      if (brk[d]) brk_cnt[d]++;
      if (dval[d] && rdy[d] && !rst) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_word: dut %0d delivered 0x%0h, expected no word", d, dout[d]);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("word_dut", 32'(d), 32'(e.dut));
          checkOutput("data_out", {24'b0, dout[d]}, {24'b0, e.data});
          checkOutput("parity_err", {31'b0, perr[d]}, {31'b0, e.perr});
          checkOutput("frame_err", {31'b0, ferr[d]}, {31'b0, e.ferr});
        end
      end
    end
  end

  initial begin
    int ovr0;
    int brk0;
    n_cmp  = 0;
    n_fail = 0;
    for (int d = 0; d < 4; d++) begin
      rxl[d]     = 1'b1;
      rdy[d]     = 1'b1;
      ovr_cnt[d] = 0;
      brk_cnt[d] = 0;
    end
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst_data_valid", {31'b0, dval[0]}, 32'd0);
    checkOutput("rst_data_out", {24'b0, dout[0]}, 32'd0);
    checkOutput("rst_busy", {31'b0, bsy[0]}, 32'd0);
    checkOutput("rst_flags", {28'b0, perr[0], ferr[0], ovr[0], brk[0]}, 32'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk);

    $display("[TB] 8N1 basic frame");
    expectWord(0, 8'hA5, 1'b0, 1'b0);
    applyStimulus(0, mkFrame(8'hA5, 0, 1'b0, 1'b1, 1'b1), 10, -1, -1);

    $display("[TB] parity frames");
    expectWord(1, 8'h3C, 1'b1, 1'b0);
    applyStimulus(1, mkFrame(8'h3C, 1, 1'b1, 1'b1, 1'b1), 11, -1, -1);
    expectWord(1, 8'h3C, 1'b0, 1'b0);
    applyStimulus(1, mkFrame(8'h3C, 1, 1'b0, 1'b1, 1'b1), 11, -1, -1);
    expectWord(2, 8'h3C, 1'b0, 1'b0);
    applyStimulus(2, mkFrame(8'h3C, 1, 1'b1, 1'b1, 1'b1), 11, -1, -1);
    expectWord(2, 8'h3C, 1'b1, 1'b0);
    applyStimulus(2, mkFrame(8'h3C, 1, 1'b0, 1'b1, 1'b1), 11, -1, -1);

    $display("[TB] two stop bits");
    expectWord(3, 8'h81, 1'b0, 1'b1);
    applyStimulus(3, mkFrame(8'h81, 0, 1'b0, 1'b1, 1'b0), 11, -1, -1);
    expectWord(3, 8'h7E, 1'b0, 1'b1);
    applyStimulus(3, mkFrame(8'h7E, 0, 1'b0, 1'b0, 1'b1), 11, -1, -1);
    expectWord(3, 8'h81, 1'b0, 1'b0);
    applyStimulus(3, mkFrame(8'h81, 0, 1'b0, 1'b1, 1'b1), 11, -1, -1);

    $display("[TB] false start glitch");
    @(posedge clk iff sample_tick);
    #1 rxl[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("glitch_busy_high", {31'b0, bsy[0]}, 32'd1);
    repeat (6) @(posedge clk);
    #1 rxl[0] = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1;
    checkOutput("glitch_busy_low", {31'b0, bsy[0]}, 32'd0);
    checkOutput("glitch_no_valid", {31'b0, dval[0]}, 32'd0);

    $display("[TB] overrun");
    ovr0   = ovr_cnt[0];
    rdy[0] = 1'b0;
    expectWord(0, 8'h11, 1'b0, 1'b0);
    applyStimulus(0, mkFrame(8'h11, 0, 1'b0, 1'b1, 1'b1), 10, -1, -1);
    applyStimulus(0, mkFrame(8'h22, 0, 1'b0, 1'b1, 1'b1), 10, -1, -1);
    checkOutput("overrun_pulses", 32'(ovr_cnt[0] - ovr0), 32'd1);
    checkOutput("overrun_kept_data", {24'b0, dout[0]}, 32'h11);
    checkOutput("overrun_kept_valid", {31'b0, dval[0]}, 32'd1);
    expectWord(0, 8'h22, 1'b0, 1'b0);
    applyStimulus(0, mkFrame(8'h22, 0, 1'b0, 1'b1, 1'b1), 10, -1, 9 * BIT_CLKS + 39);
    checkOutput("same_cycle_no_overrun", 32'(ovr_cnt[0] - ovr0), 32'd1);

    $display("[TB] break");
    brk0 = brk_cnt[0];
    @(posedge clk iff sample_tick);
    #1 rxl[0] = 1'b0;
    repeat (20 * BIT_CLKS) @(posedge clk);
    #1 rxl[0] = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1;
    checkOutput("break_pulses", 32'(brk_cnt[0] - brk0), 32'd1);
    checkOutput("break_no_valid", {31'b0, dval[0]}, 32'd0);
    checkOutput("break_busy_low", {31'b0, bsy[0]}, 32'd0);
    expectWord(0, 8'h5A, 1'b0, 1'b0);
    applyStimulus(0, mkFrame(8'h5A, 0, 1'b0, 1'b1, 1'b1), 10, -1, -1);

    $display("[TB] mid-bit noise");
    expectWord(0, 8'h5A, 1'b0, 1'b0);
    applyStimulus(0, mkFrame(8'h5A, 0, 1'b0, 1'b1, 1'b1), 10, 4 * BIT_CLKS + 32, -1);

    $display("[TB] reset mid-frame");
    fork
      applyStimulus(0, mkFrame(8'h33, 0, 1'b0, 1'b1, 1'b1), 10, -1, -1);
      begin
        @(posedge clk iff sample_tick);
        repeat (5 * BIT_CLKS + 20) @(posedge clk);
        #2;
        checkOutput("pre_rst_busy", {31'b0, bsy[0]}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_busy", {31'b0, bsy[0]}, 32'd0);
        checkOutput("async_rst_data_out", {24'b0, dout[0]}, 32'd0);
        checkOutput("async_rst_valid", {31'b0, dval[0]}, 32'd0);
      end
    join
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (BIT_CLKS) @(posedge clk);
    expectWord(0, 8'hFF, 1'b0, 1'b0);
    applyStimulus(0, mkFrame(8'hFF, 0, 1'b0, 1'b1, 1'b1), 10, -1, -1);

    repeat (BIT_CLKS) @(posedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    checkOutput("no_stray_breaks", 32'(brk_cnt[1] + brk_cnt[2] + brk_cnt[3]), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
